// File: rtl/cacheline_adapter.sv
// Cache-line adapter: turns 256-bit line fills and write-backs from the
// cache into 4-beat 64-bit bursts on the memory side.
//
// Ports:
//   clk, rst (async active-low)
//   dfp_addr/read/write/wdata -> line request from the cache (held to resp)
//   dfp_rdata/resp            <- filled line, one-cycle completion pulse
//   bmem_addr/read/write/wdata-> burst address, read request, write beats
//   bmem_ready                -> memory accepts request / write beat
//   bmem_raddr/rdata/rvalid   -> tagged returning read beats

module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  dfp_addr,
    input  logic         dfp_read,
    input  logic         dfp_write,
    input  logic [255:0] dfp_wdata,
    output logic [255:0] dfp_rdata,
    output logic         dfp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_BURST,
        RESP
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [1:0]     k;
    logic [31:0]    addr_q;
    logic [255:0]   wline_q;
    logic [255:0]   rline_q;
    logic           start;
    logic           beat_hit;
    logic           wr_acc;
    logic [7:0]     beat_lsb;
    logic           unused_addr;

    assign unused_addr = ^dfp_addr[4:0];
    assign beat_lsb    = {k, 6'd0};
    assign start       = (state == IDLE) && (dfp_read || dfp_write);

    // Only beats tagged with our line address belong to this fill.
    assign beat_hit = (state == RD_DATA) && bmem_rvalid
                      && (bmem_raddr == addr_q);
    assign wr_acc   = (state == WR_BURST) && bmem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                // Write-back wins; a held read is picked up after RESP.
                if (dfp_write)     state_n = WR_BURST;
                else if (dfp_read) state_n = RD_REQ;
            end
            RD_REQ:   if (bmem_ready) state_n = RD_DATA;
            RD_DATA:  if (beat_hit && k == 2'd3) state_n = RESP;
            WR_BURST: if (wr_acc && k == 2'd3) state_n = RESP;
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k       <= 2'd0;
            addr_q  <= 32'd0;
            wline_q <= 256'd0;
            rline_q <= 256'd0;
        end else begin
            if (start) begin
                addr_q <= {dfp_addr[31:5], 5'd0};
                k      <= 2'd0;
                if (dfp_write) wline_q <= dfp_wdata;
            end
            if (beat_hit) begin
                rline_q[beat_lsb +: 64] <= bmem_rdata;
                k <= k + 2'd1;
            end
            if (wr_acc) k <= k + 2'd1;
        end
    end

    always_comb begin
        bmem_addr  = addr_q;
        dfp_rdata  = rline_q;
        bmem_read  = (state == RD_REQ);
        bmem_write = (state == WR_BURST);
        dfp_resp   = (state == RESP);
        bmem_wdata = 64'd0;
        if (state == WR_BURST) bmem_wdata = wline_q[beat_lsb +: 64];
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: fills, write-backs, stray beats,
// mid-burst reset and stalled read requests.

module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int tests = 0;
    int fails = 0;
    int resp_cnt = 0;
    int overlap_cnt = 0;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dfp_resp) resp_cnt++;
        if (bmem_read && bmem_write) overlap_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic feed_beat(input logic [31:0] ra, input logic [63:0] d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = ra;
        bmem_rdata  = d;
        tick();
        bmem_rvalid = 1'b0;
    endtask

    // Full read with ready high and back-to-back beats.
    task automatic do_read(input string tag, input logic [31:0] a,
                           input logic [255:0] line);
        int r0;
        r0 = resp_cnt;
        dfp_addr   = a;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        chk({tag, "_rreq"}, 256'(bmem_read), 256'(1'b1));
        chk({tag, "_addr"}, 256'(bmem_addr), 256'({a[31:5], 5'd0}));
        tick();
        chk({tag, "_rreq_drop"}, 256'(bmem_read), 256'(1'b0));
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_noresp"}, 256'(dfp_resp), 256'(1'b0));
            feed_beat({a[31:5], 5'd0}, line[i*64 +: 64]);
        end
        chk({tag, "_resp"}, 256'(dfp_resp), 256'(1'b1));
        chk({tag, "_rdata"}, dfp_rdata, line);
        dfp_read = 1'b0;
        tick();
        chk({tag, "_resp_pulse"}, 256'(dfp_resp), 256'(1'b0));
        chk({tag, "_resp_cnt"}, 256'(resp_cnt - r0), 256'(1));
    endtask

    logic [255:0] line_a;
    logic [255:0] line_d;
    logic [255:0] line_b;
    logic [255:0] line_c;
    logic [255:0] line_e;
    logic [255:0] line_f;
    logic [5:0]   rdy_pat;
    int           widx;
    int           r0;

    initial begin
        line_a = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        line_d = {64'hd3d3_0000_0000_0003, 64'hd2d2_0000_0000_0002,
                  64'hd1d1_0000_0000_0001, 64'hd0d0_0000_0000_0000};
        line_b = {64'hb3, 64'hb2, 64'hb1, 64'hb0};
        line_c = {64'hc3c3, 64'hc2c2, 64'hc1c1, 64'hc0c0};
        line_e = {64'he3, 64'he2, 64'he1, 64'he0};
        line_f = {64'hf3, 64'hf2, 64'hf1, 64'hf0};

        rst         = 1'b0;
        dfp_addr    = 32'd0;
        dfp_read    = 1'b0;
        dfp_write   = 1'b0;
        dfp_wdata   = 256'd0;
        bmem_ready  = 1'b0;
        bmem_raddr  = 32'd0;
        bmem_rdata  = 64'd0;
        bmem_rvalid = 1'b0;
        tick();
        tick();
        chk("rst_resp", 256'(dfp_resp), 256'(1'b0));
        chk("rst_read", 256'(bmem_read), 256'(1'b0));
        chk("rst_write", 256'(bmem_write), 256'(1'b0));
        chk("rst_addr", 256'(bmem_addr), 256'd0);
        chk("rst_wdata", 256'(bmem_wdata), 256'd0);
        chk("rst_rdata", dfp_rdata, 256'd0);
        rst = 1'b1;

        // Basic fill of 0x1234 -> line 0x1220.
        do_read("rd1", 32'h0000_1234, line_a);
        chk("rd1_bmem_addr", 256'(bmem_addr), 256'(32'h1220));

        // Write-back with ready toggling 1,0,1,0,1,1.
        rdy_pat   = 6'b110101;
        dfp_addr  = 32'h0000_205f;
        dfp_wdata = line_d;
        dfp_write = 1'b1;
        r0 = resp_cnt;
        tick();
        chk("wr_addr", 256'(bmem_addr), 256'(32'h2040));
        chk("wr_noread", 256'(bmem_read), 256'(1'b0));
        widx = 0;
        for (int i = 0; i < 6; i++) begin
            bmem_ready = rdy_pat[i];
            chk("wr_valid", 256'(bmem_write), 256'(1'b1));
            chk("wr_beat", 256'(bmem_wdata), 256'(line_d[widx*64 +: 64]));
            chk("wr_noresp", 256'(dfp_resp), 256'(1'b0));
            tick();
            if (rdy_pat[i]) widx++;
        end
        chk("wr_resp", 256'(dfp_resp), 256'(1'b1));
        chk("wr_write_low", 256'(bmem_write), 256'(1'b0));
        chk("wr_rdata_kept", dfp_rdata, line_a);
        dfp_write = 1'b0;
        tick();
        chk("wr_resp_pulse", 256'(dfp_resp), 256'(1'b0));
        chk("wr_resp_cnt", 256'(resp_cnt - r0), 256'(1));

        // Write and read together: write-back first, then the fill.
        r0 = resp_cnt;
        overlap_cnt = 0;
        dfp_addr   = 32'h0000_3000;
        dfp_wdata  = line_d;
        dfp_write  = 1'b1;
        dfp_read   = 1'b1;
        bmem_ready = 1'b1;
        tick();
        chk("both_wr_first", 256'(bmem_write), 256'(1'b1));
        chk("both_no_rd", 256'(bmem_read), 256'(1'b0));
        tick();
        tick();
        tick();
        tick();
        chk("both_wr_resp", 256'(dfp_resp), 256'(1'b1));
        dfp_write = 1'b0;
        dfp_addr  = 32'h0000_4000;
        tick();
        chk("both_idle", 256'(bmem_read), 256'(1'b0));
        chk("both_idle_resp", 256'(dfp_resp), 256'(1'b0));
        tick();
        chk("both_rd_req", 256'(bmem_read), 256'(1'b1));
        chk("both_rd_addr", 256'(bmem_addr), 256'(32'h4000));
        tick();
        for (int i = 0; i < 4; i++)
            feed_beat(32'h0000_4000, line_b[i*64 +: 64]);
        chk("both_rd_resp", 256'(dfp_resp), 256'(1'b1));
        chk("both_rdata", dfp_rdata, line_b);
        dfp_read = 1'b0;
        tick();
        chk("both_resp_cnt", 256'(resp_cnt - r0), 256'(2));
        chk("both_overlap", 256'(overlap_cnt), 256'(0));

        // Stray beat and a gap between beats 1 and 2.
        dfp_addr = 32'h0000_5000;
        dfp_read = 1'b1;
        tick();
        tick();
        feed_beat(32'h0000_5000, line_c[63:0]);
        feed_beat(32'h0000_5000, line_c[127:64]);
        feed_beat(32'h9999_0000, 64'hbad0_bad0_bad0_bad0);
        tick();
        feed_beat(32'h0000_5000, line_c[191:128]);
        chk("stray_noresp", 256'(dfp_resp), 256'(1'b0));
        feed_beat(32'h0000_5000, line_c[255:192]);
        chk("stray_resp", 256'(dfp_resp), 256'(1'b1));
        chk("stray_rdata", dfp_rdata, line_c);
        dfp_read = 1'b0;
        tick();

        // Reset after two beats aborts the fill.
        r0 = resp_cnt;
        dfp_addr = 32'h0000_6000;
        dfp_read = 1'b1;
        tick();
        tick();
        feed_beat(32'h0000_6000, line_e[63:0]);
        feed_beat(32'h0000_6000, line_e[127:64]);
        rst = 1'b0;
        dfp_read = 1'b0;
        #1;
        chk("mrst_rdata", dfp_rdata, 256'd0);
        chk("mrst_addr", 256'(bmem_addr), 256'd0);
        chk("mrst_resp", 256'(dfp_resp), 256'(1'b0));
        tick();
        rst = 1'b1;
        feed_beat(32'h0000_6000, line_e[191:128]);
        feed_beat(32'h0000_6000, line_e[255:192]);
        tick();
        chk("mrst_no_resp", 256'(resp_cnt - r0), 256'(0));
        chk("mrst_ignored", dfp_rdata, 256'd0);
        do_read("rd_after_rst", 32'h0000_6000, line_e);

        // Memory stalls the read request for 10 cycles.
        dfp_addr   = 32'h0000_7000;
        dfp_read   = 1'b1;
        bmem_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("stall_rreq", 256'(bmem_read), 256'(1'b1));
            feed_beat(32'h0000_7000, 64'hdead);
        end
        chk("stall_rdata", dfp_rdata, line_e);
        bmem_ready = 1'b1;
        tick();
        chk("stall_rreq_low", 256'(bmem_read), 256'(1'b0));
        for (int i = 0; i < 4; i++)
            feed_beat(32'h0000_7000, line_f[i*64 +: 64]);
        chk("stall_resp", 256'(dfp_resp), 256'(1'b1));
        chk("stall_rdata_new", dfp_rdata, line_f);
        dfp_read = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have no parameters; the line is fixed at 256 bits, the beat at 64 bits, and a burst at 4 beats.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 dfp_addr  input  32  line address from cache; bits [4:0] are ignored.
REQ-005 dfp_read  input  1  line-fill request, level, held by the cache until dfp_resp.
REQ-006 dfp_write  input  1  line write-back request, level, held until dfp_resp.
REQ-007 dfp_wdata  input  256  write-back line, stable while dfp_write is high.
REQ-008 dfp_rdata  output  256  filled line.
REQ-009 dfp_resp  output  1  one-cycle completion pulse.
REQ-010 bmem_addr  output  32  burst address, line-aligned.
REQ-011 bmem_read  output  1  read-burst request.
REQ-012 bmem_write  output  1  write beat valid.
REQ-013 bmem_wdata  output  64  write beat data.
REQ-014 bmem_ready  input  1  memory accepts the read request or write beat this cycle.
REQ-015 bmem_raddr  input  32  address tag of the returning read beat.
REQ-016 bmem_rdata  input  64  read beat data.
REQ-017 bmem_rvalid  input  1  read beat valid.

Function
REQ-018 FSM states SHALL be IDLE, RD_REQ, RD_DATA, WR_BURST and RESP.
REQ-019 IDLE: on dfp_write go to WR_BURST; on dfp_read alone go to RD_REQ; with both high, write wins and the read SHALL be serviced after RESP.
REQ-020 On leaving IDLE, the adapter SHALL latch {dfp_addr[31:5],5'b0} into the address register and, for a write, latch dfp_wdata; bmem_addr SHALL come from that register.
REQ-021 Requests SHALL be sampled only in IDLE; dfp_read and dfp_write are ignored in every other state, including RESP.
REQ-022 RD_REQ: bmem_read=1; when bmem_ready=1, go to RD_DATA; bmem_read SHALL be high for exactly the cycles spent in RD_REQ.
REQ-023 RD_DATA: each cycle with bmem_rvalid=1 and bmem_raddr == latched address SHALL write bmem_rdata into beat k = bits [64k+63:64k] and increment the 2-bit beat counter k.
REQ-024 RD_DATA: beats with a raddr mismatch SHALL be ignored; gaps between beats are allowed.
REQ-025 RD_DATA: after beat 3 is captured, go to RESP.
REQ-026 WR_BURST: bmem_write=1 and bmem_wdata = latched line bits [64k+63:64k].
REQ-027 WR_BURST: k SHALL advance only when bmem_ready=1; after beat 3 is accepted, go to RESP; bmem_wdata SHALL hold while bmem_ready=0.
REQ-028 RESP: dfp_resp=1 for exactly one cycle, then go to IDLE; a request still high in the RESP cycle is not restarted.
REQ-029 Latency: dfp_resp SHALL rise the cycle after the 4th accepted beat (read or write).
REQ-030 Minimum read latency SHALL be 1 (RD_REQ) + 4 beats + 1 (RESP).
REQ-031 Minimum write latency SHALL be 4 + 1 cycles.
REQ-032 dfp_rdata SHALL be registered, valid in the RESP cycle, and held unchanged until the next read's beats arrive; writes SHALL NOT alter it.
REQ-033 bmem_read and bmem_write SHALL never be high in the same cycle.
REQ-034 The beat counter SHALL wrap 3->0 and be cleared on every entry to RD_REQ or WR_BURST.

Reset
REQ-035 While rst=0: state=IDLE, k=0, dfp_resp=0, bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0, dfp_rdata=0.
REQ-036 Reset asserted mid-burst SHALL abort the burst with no dfp_resp.
REQ-037 Beats arriving after reset deassertion SHALL be ignored until a new read is issued.
REQ-038 The first request after reset release SHALL be accepted on the first clk edge with rst=1.

Verification
REQ-039 Read, addr 0x0000_1234, bmem_ready=1, 4 back-to-back rvalid beats with raddr 0x1220 carrying 0x11..,0x22..,0x33..,0x44.. -> bmem_addr=0x1220, single dfp_resp, dfp_rdata = {0x44..,0x33..,0x22..,0x11..}.
REQ-040 Write of line D with bmem_ready toggling 1,0,1,0,1,1 -> beats D[63:0]..D[255:192] in order, each held while not ready, dfp_resp one cycle after the 4th accept.
REQ-041 dfp_write and dfp_read both high, held (write-back then fill), different addresses -> write burst completes, RESP, IDLE, then read burst; exactly two dfp_resp pulses; no overlap of bmem_read and bmem_write.
REQ-042 Read with one stray beat (raddr 0x9999_0000) inserted between beats 1 and 2 -> stray beat discarded, line correct.
REQ-043 rst=0 asserted after 2 read beats, then released -> outputs zero immediately, no dfp_resp, remaining beats ignored, next read completes correctly.
REQ-044 bmem_ready held 0 for 10 cycles in RD_REQ -> bmem_read stays high, no data is captured, and the FSM proceeds normally once ready rises.
